// File: rtl/mvu_stream_pkg.sv
// Shared sizing helpers and weight-stream types for the VVU weight streamer.
package mvu_stream_pkg;

    localparam int unsigned MW_DEF           = 25;
    localparam int unsigned MH_DEF           = 4;
    localparam int unsigned PE_DEF           = 1;
    localparam int unsigned SIMD_DEF         = 1;
    localparam int unsigned WEIGHT_WIDTH_DEF = 4;

    function automatic int unsigned calc_nf(input int unsigned mh, input int unsigned pe);
        return mh / pe;
    endfunction

    function automatic int unsigned calc_sf(input int unsigned mw, input int unsigned simd);
        return mw / simd;
    endfunction

    function automatic int unsigned calc_depth(input int unsigned mw, input int unsigned mh,
                                               input int unsigned pe, input int unsigned simd);
        return calc_nf(mh, pe) * calc_sf(mw, simd);
    endfunction

    function automatic int unsigned calc_word_w(input int unsigned pe, input int unsigned simd,
                                                input int unsigned ww);
        return pe * simd * ww;
    endfunction

    // AXI-stream data must be a whole number of bytes.
    function automatic int unsigned calc_stream_w(input int unsigned word_w);
        return (word_w + 7) / 8 * 8;
    endfunction

    localparam int unsigned NF       = calc_nf(MH_DEF, PE_DEF);
    localparam int unsigned SF       = calc_sf(MW_DEF, SIMD_DEF);
    localparam int unsigned DEPTH    = NF * SF;
    localparam int unsigned WORD_W   = calc_word_w(PE_DEF, SIMD_DEF, WEIGHT_WIDTH_DEF);
    localparam int unsigned STREAM_W = calc_stream_w(WORD_W);

    typedef logic [PE_DEF-1:0][SIMD_DEF-1:0][WEIGHT_WIDTH_DEF-1:0] weight_word_t;

    typedef struct packed {
        weight_word_t dat;
        logic         last;
    } fifo_entry_t;

endpackage

// File: rtl/vvu_weight_streamer_if.sv
// AXI-stream weight bus between the streamer and the MVU/VVU wrapper.
interface vvu_weight_streamer_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_fifo.sv
// Shift-style FIFO whose head is always slot 0; zero-latency head, count output,
// push and pop together at any occupancy including full.
module stream_fifo #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_dat,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 head_dat,
    output logic                             head_vld,
    output logic [$clog2(ENTRIES+1)-1:0]     count
);
    localparam int unsigned CW = $clog2(ENTRIES + 1);
    localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [WIDTH-1:0] slot     [ENTRIES];
    logic [WIDTH-1:0] slot_nxt [ENTRIES];
    logic [CW-1:0]    cnt_q;
    logic             do_pop;
    logic             do_push;
    logic [IW-1:0]    wr_idx;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q < CW'(ENTRIES)) || do_pop);

    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            slot_nxt[i] = slot[i];
            if (do_pop && (i < ENTRIES - 1)) begin
                slot_nxt[i] = slot[IW'((i + 1) % ENTRIES)];
            end
        end
        // After a pop the first free slot moves down by one.
        if (do_push) begin
            wr_idx           = IW'(do_pop ? cnt_q - 1'b1 : cnt_q);
            slot_nxt[wr_idx] = push_dat;
        end
    end

    always_ff @(posedge clk) begin
        slot <= slot_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_dat = slot[0];
    assign head_vld = (cnt_q != '0);
    assign count    = cnt_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && (cnt_q == CW'(ENTRIES))));

endmodule

// File: rtl/vvu_weight_streamer.sv
// Replays an NF*SF weight memory as an endless AXI-stream in nf-major/sf order.
// Read-to-FIFO latency 2 edges after issue; credit (occupancy + in-flight) stalls reads on back-pressure.
module vvu_weight_streamer
    import mvu_stream_pkg::*;
#(
    parameter int unsigned MW           = 25,
    parameter int unsigned MH           = 4,
    parameter int unsigned PE           = 1,
    parameter int unsigned SIMD         = 1,
    parameter int unsigned WEIGHT_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                       ap_clk,
    input  logic                                       ap_rst,
    input  logic                                       en,
    input  logic                                       cfg_we,
    input  logic [$clog2((MH/PE)*(MW/SIMD))-1:0]       cfg_addr,
    input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]            cfg_wdata,
    vvu_weight_streamer_if.master                      m_axis_weights,
    output logic                                       busy
);
    localparam int unsigned MEM_DEPTH   = calc_depth(MW, MH, PE, SIMD);
    localparam int unsigned WORD_BITS   = calc_word_w(PE, SIMD, WEIGHT_WIDTH);
    localparam int unsigned STREAM_BITS = calc_stream_w(WORD_BITS);
    localparam int unsigned AW          = $clog2(MEM_DEPTH);
    localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUMW        = CW + 1;

    typedef struct packed {
        logic [WORD_BITS-1:0] dat;
        logic                 last;
    } entry_t;

    logic [WORD_BITS-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]        ptr;
    logic                 ptr_at_end;
    logic                 issue;
    logic                 s1_vld, s1_last, s2_vld, s2_last;
    logic [WORD_BITS-1:0] s1_dat, s2_dat;
    logic [1:0]           in_flight;
    logic [CW-1:0]        fifo_count;
    entry_t               push_entry;
    entry_t               head_entry;
    logic                 head_vld;
    logic                 pop;

    assign ptr_at_end = (ptr == AW'(MEM_DEPTH - 1));
    assign in_flight  = 2'(s1_vld) + 2'(s2_vld);

    // Counting in-flight reads as occupied slots guarantees a landing slot for every issued read.
    assign issue = en && !cfg_we &&
                   ((SUMW'(fifo_count) + SUMW'(in_flight)) < SUMW'(FIFO_DEPTH));

    // Single port: a config write takes the port and suppresses that cycle's read.
    always_ff @(posedge ap_clk) begin
        if (cfg_we) begin
            mem[cfg_addr] <= cfg_wdata;
        end else if (issue) begin
            s1_dat <= mem[ptr];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (s1_vld) begin
            s2_dat <= s1_dat;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr     <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s1_vld  <= issue;
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            if (issue) begin
                s1_last <= ptr_at_end;
                ptr     <= ptr_at_end ? '0 : ptr + 1'b1;
            end
        end
    end

    assign push_entry.dat  = s2_dat;
    assign push_entry.last = s2_last;

    stream_fifo #(
        .ENTRIES (FIFO_DEPTH),
        .WIDTH   ($bits(entry_t))
    ) u_fifo (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .push     (s2_vld),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head_entry),
        .head_vld (head_vld),
        .count    (fifo_count)
    );

    assign pop = head_vld && m_axis_weights.tready;

    assign m_axis_weights.tvalid = head_vld;
    assign m_axis_weights.tdata  = STREAM_BITS'(head_entry.dat);
    assign m_axis_weights.tlast  = head_vld && head_entry.last;

    assign busy = en || (in_flight != 2'd0) || (fifo_count != '0);

endmodule
